// File: rtl/gray_rgb_packer_pkg.sv
// Shared types and helpers for the grayscale-to-packed-RGB stream packer.
package gray_pkg;

  typedef enum logic [2:0] {
    PH0   = 3'd0,
    PH1   = 3'd1,
    PH2   = 3'd2,
    PH3   = 3'd3,
    FLUSH = 3'd4
  } state_t;

  localparam int PIX_BYTES  = 3;
  localparam int WORD_BYTES = 4;

  // Callers zero-extend the pixel to 32 bits; values above 255 only clamp when enabled.
  function automatic logic [7:0] sat8(input logic [31:0] d, input logic sat_en);
    if (sat_en && (d > 32'd255)) return 8'hFF;
    return d[7:0];
  endfunction

endpackage

// File: rtl/gray_rgb_packer_if.sv
// Pixel input stream and packed-word output stream of the packer.
interface gray_rgb_packer_if #(
  parameter int IN_W = 9
);
  // Both streams: a transfer happens on a clock edge where valid && ready;
  // valid never waits for ready, and payload is held stable while valid && !ready.
  logic            s_valid;
  logic            s_ready;
  logic [IN_W-1:0] s_data;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [31:0]     m_data;
  logic [3:0]      m_keep;
  logic            m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );
endinterface

// File: rtl/gray_rgb_packer.sv
// Expands grayscale pixels to R=G=B bytes and packs them densely into 32-bit words
// (4 pixels -> 3 words), flushing a zero-padded partial word at end of frame.
module gray_rgb_packer
  import gray_pkg::*;
#(
  parameter int IN_W   = 9,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 24
) (
  input  logic             s00_axi_aclk,
  input  logic             s00_axi_aresetn,
  gray_rgb_packer_if.slave bus,
  output logic [CNT_W-1:0] pix_count,
  output logic             frame_done,
  output state_t           state
);

  logic        load_ok;
  logic        in_hs;
  logic        accept;
  logic [7:0]  g;
  logic [23:0] hold;
  logic        two_left;
  logic        m_valid_q;
  logic [31:0] m_data_q;
  logic [3:0]  m_keep_q;
  logic        m_last_q;

  assign load_ok     = !m_valid_q || bus.m_ready;
  assign bus.s_ready = s00_axi_aresetn && (state != FLUSH) && load_ok;
  assign in_hs       = bus.s_valid && bus.s_ready;
  assign accept      = m_valid_q && bus.m_ready;
  assign g           = sat8(32'(bus.s_data), SAT_EN != 0);

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_keep  = m_keep_q;
  assign bus.m_last  = m_last_q;

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state      <= PH0;
      hold       <= '0;
      two_left   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      pix_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && m_last_q;

      // A new frame's first pixel can arrive in the same cycle the old frame closes.
      if (accept && m_last_q)
        pix_count <= in_hs ? CNT_W'(1) : '0;
      else if (in_hs)
        pix_count <= pix_count + CNT_W'(1);

      // Any word load below overrides this drain.
      if (accept) m_valid_q <= 1'b0;

      case (state)
        PH0: if (in_hs) begin
          if (bus.s_last) begin
            m_valid_q <= 1'b1;
            m_data_q  <= {8'h00, g, g, g};
            m_keep_q  <= 4'b0111;
            m_last_q  <= 1'b1;
          end else begin
            hold  <= {g, g, g};
            state <= PH1;
          end
        end
        PH1: if (in_hs) begin
          m_valid_q <= 1'b1;
          m_data_q  <= {g, hold[23:0]};
          m_keep_q  <= 4'b1111;
          m_last_q  <= 1'b0;
          hold      <= {8'h00, g, g};
          two_left  <= 1'b1;
          state     <= bus.s_last ? FLUSH : PH2;
        end
        PH2: if (in_hs) begin
          m_valid_q <= 1'b1;
          m_data_q  <= {g, g, hold[15:0]};
          m_keep_q  <= 4'b1111;
          m_last_q  <= 1'b0;
          hold      <= {16'h0000, g};
          two_left  <= 1'b0;
          state     <= bus.s_last ? FLUSH : PH3;
        end
        PH3: if (in_hs) begin
          m_valid_q <= 1'b1;
          m_data_q  <= {g, g, g, hold[7:0]};
          m_keep_q  <= 4'b1111;
          m_last_q  <= bus.s_last;
          state     <= PH0;
        end
        FLUSH: if (load_ok) begin
          m_valid_q <= 1'b1;
          m_data_q  <= two_left ? {16'h0000, hold[15:0]} : {24'h000000, hold[7:0]};
          m_keep_q  <= two_left ? 4'b0011 : 4'b0001;
          m_last_q  <= 1'b1;
          state     <= PH0;
        end
        default: state <= PH0;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_rgb_packer.sv
// Randomized and directed bench for gray_rgb_packer against a byte-queue packing model.
module tb_gray_rgb_packer;
  import gray_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [23:0] pix_count;
  logic        frame_done;
  state_t      dbg_state;

  gray_rgb_packer_if #(.IN_W(9)) bus ();

  gray_rgb_packer #(.IN_W(9), .SAT_EN(1), .CNT_W(24)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .bus             (bus.slave),
    .pix_count       (pix_count),
    .frame_done      (frame_done),
    .state           (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp;
  int          n_bad;
  logic [36:0] exp_q[$];   // {last, keep, data}
  logic        mon_en;
  logic        bp_en;
  int          model_pc;
  logic        fd_model;
  logic        hold_prev;
  logic [31:0] prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [8:0] d);
    return (d > 9'd255) ? 8'hFF : d[7:0];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic        acc;
      logic        hs;
      logic        fd_next;
      logic [36:0] e;
      check("pix_count", 32'(pix_count), 32'(model_pc));
      check("frame_done", 32'(frame_done), 32'(fd_model));
      if (hold_prev) begin
        check("stall_valid", 32'(bus.m_valid), 32'd1);
        check("stall_data", bus.m_data, prev_data);
      end
      acc     = bus.m_valid && bus.m_ready;
      hs      = bus.s_valid && bus.s_ready;
      fd_next = 1'b0;
      if (acc) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word got=%h expected none", bus.m_data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", bus.m_data, e[31:0]);
          check("m_keep", 32'(bus.m_keep), 32'(e[35:32]));
          check("m_last", 32'(bus.m_last), 32'(e[36]));
          fd_next = e[36];
        end
      end
      if (acc && fd_next) model_pc = hs ? 1 : 0;
      else if (hs)        model_pc = (model_pc + 1) % (1 << 24);
      fd_model  = fd_next;
      hold_prev = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
    end
  end

  // ---------------- downstream ready driver ----------------
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_px(input logic [8:0] d, input logic last);
    int   waited;
    logic ok;
    waited = 0;
    ok     = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!ok && waited < 1000) begin
      @(negedge clk);
      if (bus.s_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
        waited++;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL s_ready_timeout got=0 exp=1");
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back({l, k, d});
  endtask

  // Reference packing: expand to a byte stream, then cut into 4-byte words.
  task automatic send_frame_model(input int n);
    logic [8:0]  px[$];
    logic [7:0]  bq[$];
    logic [31:0] w;
    logic [3:0]  k;
    for (int i = 0; i < n; i++) begin
      px.push_back(9'($urandom_range(0, 511)));
      for (int b = 0; b < PIX_BYTES; b++) bq.push_back(ref_byte(px[i]));
    end
    while (bq.size() > 0) begin
      w = '0;
      k = '0;
      for (int j = 0; j < WORD_BYTES; j++) begin
        if (bq.size() > 0) begin
          w[8*j +: 8] = bq.pop_front();
          k[j]        = 1'b1;
        end
      end
      push_exp(w, k, bq.size() == 0);
    end
    for (int i = 0; i < n; i++) send_px(px[i], i == n - 1);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || bus.m_valid) && c < 5000) begin
      @(posedge clk);
      c++;
    end
    if (c >= 5000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout got=%0d words left exp=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_m_data"}, bus.m_data, 32'd0);
    check({tag, "_m_keep"}, 32'(bus.m_keep), 32'd0);
    check({tag, "_m_last"}, 32'(bus.m_last), 32'd0);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    check({tag, "_pix_count"}, 32'(pix_count), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(PH0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sent;
    n_cmp = 0; n_bad = 0;
    mon_en = 1'b0; bp_en = 1'b0;
    model_pc = 0; fd_model = 1'b0; hold_prev = 1'b0; prev_data = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Four pixels -> three full words
    push_exp(32'h20101010, 4'hF, 1'b0);
    push_exp(32'h30302020, 4'hF, 1'b0);
    push_exp(32'h40404030, 4'hF, 1'b1);
    send_px(9'h010, 1'b0); send_px(9'h020, 1'b0);
    send_px(9'h030, 1'b0); send_px(9'h040, 1'b1);
    wait_drain();

    // Single pixel frame
    push_exp(32'h00555555, 4'b0111, 1'b1);
    send_px(9'h055, 1'b1);
    wait_drain();

    // Two pixels: full word then a 2-byte flush; input stalls during flush
    push_exp(32'hBBAAAAAA, 4'hF, 1'b0);
    push_exp(32'h0000BBBB, 4'b0011, 1'b1);
    send_px(9'h0AA, 1'b0);
    send_px(9'h0BB, 1'b1);
    @(negedge clk);
    check("flush_s_ready", 32'(bus.s_ready), 32'd0);
    check("flush_state", 32'(dbg_state), 32'(FLUSH));
    wait_drain();

    // Three pixels: two words then a 1-byte flush
    push_exp(32'h02010101, 4'hF, 1'b0);
    push_exp(32'h03030202, 4'hF, 1'b0);
    push_exp(32'h00000003, 4'b0001, 1'b1);
    send_px(9'h001, 1'b0); send_px(9'h002, 1'b0); send_px(9'h003, 1'b1);
    wait_drain();

    // Saturation of out-of-range pixel
    push_exp(32'h00FFFFFF, 4'b0111, 1'b1);
    send_px(9'h1FF, 1'b1);
    wait_drain();

    // Random frames under random backpressure
    bp_en = 1'b1;
    sent  = 0;
    while (sent < 1000) begin
      int n;
      n = $urandom_range(1, 12);
      send_frame_model(n);
      sent += n;
    end
    wait_drain();
    bp_en = 1'b0;
    wait_drain();

    // Reset in the middle of a frame discards everything buffered
    mon_en = 1'b0;
    send_px(9'h011, 1'b0);
    send_px(9'h022, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    model_pc = 0; fd_model = 1'b0; hold_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    push_exp(32'h00777777, 4'b0111, 1'b1);
    send_px(9'h077, 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_rgb_packer.md
Name: gray_rgb_packer

Overview:
Streaming back-end that takes grayscale pixels from the conversion datapath and expands each one into a 24-bit RGB pixel with R=G=B.
It packs these 3-byte pixels densely into 32-bit words for the DMA write path, so 4 pixels become 3 words.
On end of frame it flushes any partial word, zero-padded, with byte-enable keep bits and a last flag.
It sits between the converter output stream and the AXI-Stream master feeding the write DMA.

Parameters:
IN_W, 9, input pixel width; the converter emits 9 bits with a legal range of 0..255.
SAT_EN, 1, 1 = clamp inputs above 255 to 255; 0 = truncate to bits [7:0].
CNT_W, 24, width of the frame pixel counter.

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid && s_ready
s_data  in  IN_W  grayscale pixel
s_last  in  1  last pixel of frame
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_data  out  32  packed RGB bytes; byte0 = [7:0] is the first byte in memory order
m_keep  out  4  byte enables for m_data
m_last  out  1  last word of frame
pix_count  out  CNT_W  pixels accepted in the current frame
frame_done  out  1  one-cycle pulse when a word with m_last is accepted downstream

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low (s00_axi_aresetn).
  - While reset is asserted, all of the following are 0: m_valid, m_data, m_keep, m_last, frame_done, pix_count, the hold register and s_ready.
  - The FSM resets to PH0.
  - A reset mid-frame discards all buffered bytes and any pending output word. No partial word is emitted.
- Pixel byte g:
  - If SAT_EN=1: g = (s_data > 255) ? 8'hFF : s_data[7:0].
  - If SAT_EN=0: g = s_data[7:0].
  - Each pixel contributes the bytes R,G,B = g,g,g, in that order.
- Output register: a single stage holding m_data, m_keep, m_last and m_valid.
  - Load condition: load_ok = !m_valid || m_ready.
  - s_ready = (state != FLUSH) && load_ok.
  - m_valid clears on m_ready unless a new word loads in the same cycle. A simultaneous accept and load is legal, giving 1 word/cycle throughput.
- FSM states PH0, PH1, PH2, PH3, FLUSH. Transitions below happen on an input handshake; hold is the register of buffered bytes.
  - PH0: hold <= {g,g,g} (3 bytes), go to PH1, no output.
    - If s_last: emit {00,g,g,g}, keep=0111, last=1, then go to PH0.
  - PH1: emit {g,h2,h1,h0}, keep=1111, hold <= {g,g}, go to PH2.
    - If s_last: last=0, go to FLUSH with 2 bytes left.
  - PH2: emit {g,g,h1,h0}, keep=1111, hold <= {g}, go to PH3.
    - If s_last: go to FLUSH with 1 byte left.
  - PH3: emit {g,g,g,h0}, keep=1111, go to PH0.
    - If s_last: last=1 on this word.
  - FLUSH: when load_ok, emit the held bytes zero-padded with last=1.
    - 2 bytes left: keep=0011.
    - 1 byte left: keep=0001.
    - Then go to PH0; s_ready is 0 while in FLUSH.
- pix_count:
  - Increments on each input handshake.
  - Clears on the cycle the m_last word is accepted, i.e. m_valid && m_ready && m_last.
  - Wraps modulo 2^CNT_W with no error flag.
- frame_done: registered, high for exactly 1 cycle after each m_last word is accepted.
- Latency: a completed word is visible on m_valid the cycle after the input handshake that completes it.
- Data is never dropped or duplicated under any m_ready pattern.

Decomposition:
- Package gray_pkg:
  - state enum {PH0, PH1, PH2, PH3, FLUSH}.
  - Constants PIX_BYTES=3 and WORD_BYTES=4.
  - Function sat8() implementing the clamp.
- No sub-module. The output register is small enough to stay inline; do not split it into a skid buffer.

Test Plan:
- 4 pixels 0x10, 0x20, 0x30, 0x40 (last on the 4th), m_ready=1 -> 3 words:
  - 0x20101010 keep F
  - 0x30302020 keep F
  - 0x40404030 keep F, last=1
  - then frame_done pulse and pix_count=0.
- Single pixel 0x55 with last -> one word 0x00555555, keep=0111, last=1.
- 2 pixels 0xAA, 0xBB with last -> 0xBBAAAAAA keep F last=0, then a FLUSH word 0x0000BBBB keep=0011 last=1. s_ready must stay low for the FLUSH cycle.
- 3 pixels 0x01, 0x02, 0x03 with last -> 0x02010101, then 0x03030202, then 0x00000003 keep=0001 last=1. Separately, with SAT_EN=1, input 9'h1FF yields bytes 0xFF.
- Random m_ready backpressure (~50%) over 1000 pixels -> word stream equals the reference packing with no loss, and m_data stable while m_valid && !m_ready.
- Assert reset after 2 pixels of a frame -> outputs are 0 immediately. A following 1-pixel frame 0x77 yields exactly 0x00777777 keep=0111 last=1.
